// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input.
// The pin is synchronized through three flops. The block reports the high
// time and the full period, rising edge to rising edge, of each complete
// cycle. It also flags a stalled line after TIMEOUT cycles with no edge.
module pwm_capture #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 32767
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pwm,
  output logic [WIDTH-1:0] o_high,
  output logic [WIDTH-1:0] o_period,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_level
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [WIDTH-1:0] QUIET_MAX = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] QUIET_PRE = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic             fall;
  logic             any_edge;
  logic             stall;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] quiet;
  logic [WIDTH-1:0] r_high;

  // The third flop exists only to give edge detection a previous value.
  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign any_edge = rise | fall;
  assign o_level  = s2;

  // The period counter holds at its maximum instead of wrapping.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + ONE;

  // A stall is declared on the cycle quiet reaches TIMEOUT. An edge in
  // that same cycle clears quiet instead, so the edge wins.
  assign stall = ~any_edge & (quiet == QUIET_PRE);

  // Synchronizer chain. It resets high so a pin already high at reset
  // does not look like a rising edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= i_pwm;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Count cycles since the last edge of either polarity, saturating at TIMEOUT.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      quiet <= '0;
    end else if (any_edge) begin
      quiet <= '0;
    end else if (quiet != QUIET_MAX) begin
      quiet <= quiet + ONE;
    end
  end

  // Measurement FSM. The first rise only arms it, and each later rise
  // publishes the cycle that just ended.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      r_high    <= '0;
      o_high    <= '0;
      o_period  <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            cnt   <= ONE;
            state <= HIGH;
          end else if (stall) begin
            o_timeout <= 1'b1;
          end
        end

        HIGH: begin
          if (fall) begin
            r_high <= cnt;
            cnt    <= cnt_inc;
            state  <= LOW;
          end else if (stall) begin
            o_valid   <= 1'b1;
            o_high    <= '0;
            o_period  <= '0;
            o_timeout <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        LOW: begin
          if (rise) begin
            o_period  <= cnt;
            o_high    <= r_high;
            o_valid   <= 1'b1;
            o_timeout <= 1'b0;
            cnt       <= ONE;
            state     <= HIGH;
          end else if (stall) begin
            o_valid   <= 1'b1;
            o_high    <= '0;
            o_period  <= '0;
            o_timeout <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed, table-driven bench for pwm_capture.
module tb_pwm_capture;

  localparam int W  = 16;
  localparam int TO = 100;

  typedef struct {
    int h;
    int l;
    int reps;
    int exp_h;
    int exp_p;
  } vec_t;

  typedef struct {
    int   h;
    int   p;
    logic to;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         pwm;
  logic [W-1:0] high;
  logic [W-1:0] period;
  logic         valid;
  logic         timeout;
  logic         level;

  vec_t vecs[4];
  exp_t exp_q[$];
  exp_t prev;
  bit   have_prev = 1'b0;
  bit   lvl_en    = 1'b0;
  logic h1        = 1'b1;
  logic h2        = 1'b1;
  int   checks    = 0;
  int   errors    = 0;
  int   n;

  pwm_capture #(
    .WIDTH  (W),
    .TIMEOUT(TO)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_pwm    (pwm),
    .o_high   (high),
    .o_period (period),
    .o_valid  (valid),
    .o_timeout(timeout),
    .o_level  (level)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value and count the result.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Advance n clocks, leaving the bench 1 ns after a rising edge.
  task automatic waitCycles(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one PWM cycle. Its expected result is queued at the next rise.
  task automatic applyStimulus(input int h, input int l, input int exp_h, input int exp_p);
    if (have_prev) exp_q.push_back(prev);
    prev      = '{exp_h, exp_p, 1'b0};
    have_prev = 1'b1;
    pwm = 1'b1;
    waitCycles(h);
    pwm = 1'b0;
    waitCycles(l);
  endtask

  // Check all outputs against their reset values.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_high"}, high, 0);
    checkOutput({tag, "_period"}, period, 0);
    checkOutput({tag, "_valid"}, valid, 0);
    checkOutput({tag, "_timeout"}, timeout, 0);
    checkOutput({tag, "_level"}, level, 1);
  endtask

  // Score every strobe against the queue, and check that o_level lags the pin by 2 clocks.
  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe at %0t: got high=%0d period=%0d, expected no strobe",
                 $time, high, period);
      end else begin
        e = exp_q.pop_front();
        checkOutput("strobe_high", high, e.h);
        checkOutput("strobe_period", period, e.p);
        checkOutput("strobe_timeout", timeout, e.to);
      end
    end
    if (lvl_en) checkOutput("level_lag", level, h2);
    h2 = h1;
    h1 = pwm;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    vecs[0] = '{10, 30, 3, 10, 40};
    vecs[1] = '{25, 15, 3, 25, 40};
    vecs[2] = '{1, 1, 8, 1, 2};
    vecs[3] = '{3, 7, 2, 3, 10};

    // Reset with the pin low.
    pwm   = 1'b0;
    rst_n = 1'b0;
    waitCycles(3);
    @(negedge clk);
    checkResetValues("reset_pin_low");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitCycles(5);
    lvl_en = 1'b1;

    // Continuous stream through the table. The first rise only arms.
    $display("[TB] table-driven stream");
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < vecs[i].reps; r++)
        applyStimulus(vecs[i].h, vecs[i].l, vecs[i].exp_h, vecs[i].exp_p);

    // Flush the last cycle, then stall the line low from the LOW state.
    $display("[TB] stall sequence");
    exp_q.push_back(prev);
    have_prev = 1'b0;
    pwm = 1'b1;
    waitCycles(5);
    pwm = 1'b0;
    exp_q.push_back('{0, 0, 1'b1});
    n = 0;
    while (level !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (timeout !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_latency", n, TO + 1);
    @(posedge clk);
    #1;
    waitCycles(20);
    checkOutput("timeout_held", timeout, 1);
    checkOutput("pending_after_stall", exp_q.size(), 0);

    // Resume with H=5, L=5. The timeout clears at the second rise.
    applyStimulus(5, 5, 5, 10);
    checkOutput("timeout_held_after_arm", timeout, 1);
    applyStimulus(5, 5, 5, 10);
    applyStimulus(5, 5, 5, 10);
    checkOutput("timeout_cleared", timeout, 0);

    // Assert reset mid-HIGH, then release it while the pin is high.
    $display("[TB] reset mid-HIGH");
    exp_q.push_back(prev);
    have_prev = 1'b0;
    pwm = 1'b1;
    waitCycles(6);
    checkOutput("pending_before_reset", exp_q.size(), 0);
    lvl_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkResetValues("reset_mid_high");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitCycles(7);
    lvl_en = 1'b1;
    pwm = 1'b0;
    waitCycles(30);
    for (int r = 0; r < 3; r++) applyStimulus(10, 30, 10, 40);

    // Closing rise. The strobe must appear 3 clocks after the pin is sampled.
    exp_q.push_back(prev);
    have_prev = 1'b0;
    pwm = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid !== 1'b1 && n < 20);
    checkOutput("strobe_latency", n, 4);
    @(posedge clk);
    #1;
    waitCycles(5);
    checkOutput("pending_at_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
